matrix_frame_loader: RTL and testbench

- Frame source feeding the dot-matrix driver's load interface.
- Holds a 32-column x 16-bit pattern store written by the host.
- On a start request, streams NUM_COLS columns to the driver: column_id/in_column with a one-cycle LOAD strobe per column, and an optional IN_CLR pulse first.
- Supports horizontal scrolling via an auto-incrementing read offset.

---
 rtl/matrix_frame_loader.sv | 169 ++++++++++++++++
 tb/tb_matrix_frame_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_loader.sv
// rtl/matrix_frame_loader.sv - pattern store and column streamer for the dot-matrix driver load interface
// Streams NUM_COLS columns per start request, optional clear first, with an auto-advancing scroll offset.
module matrix_frame_loader #(
    parameter int NUM_COLS = 16,
    parameter int DEPTH    = 32,
    parameter int GAP      = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        start,
    input  logic        clear_req,
    input  logic        scroll_en,
    input  logic        offset_ld,
    input  logic [4:0]  offset_in,
    output logic [4:0]  column_id,
    output logic [15:0] in_column,
    output logic        LOAD,
    output logic        IN_CLR,
    output logic        busy,
    output logic        done,
    output logic [4:0]  offset
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LD,
        S_GAP,
        S_FIN
    } state_t;

    localparam logic [4:0] LAST_COL = 5'(NUM_COLS - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit         HAS_GAP  = (GAP > 0);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] store [DEPTH];
    logic [4:0]  col_idx;
    logic [3:0]  gap_cnt;
    logic        scroll_q;
    logic [4:0]  rd_addr;
    logic        last_col;
    logic        gap_done;

    logic        load_nxt;
    logic        clr_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic [4:0]  column_id_nxt;
    logic [15:0] in_column_nxt;

    // 5-bit add wraps naturally, giving the modulo-32 scroll window
    assign rd_addr  = col_idx + offset;
    assign last_col = (col_idx == LAST_COL);
    assign gap_done = (gap_cnt == GAP_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = clear_req ? S_CLR : S_LD;
                end
            end
            S_CLR: state_nxt = S_LD;
            S_LD: begin
                if (last_col) begin
                    state_nxt = S_FIN;
                end else if (HAS_GAP) begin
                    state_nxt = S_GAP;
                end else begin
                    state_nxt = S_LD;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_nxt = S_LD;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered, so they appear one cycle after the state that produces them
    always_comb begin
        load_nxt      = (state == S_LD);
        clr_nxt       = (state == S_CLR);
        done_nxt      = (state == S_FIN);
        busy_nxt      = (state_nxt != S_IDLE);
        column_id_nxt = column_id;
        in_column_nxt = in_column;
        if (state == S_LD) begin
            column_id_nxt = col_idx;
            in_column_nxt = store[rd_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            column_id <= '0;
            in_column <= '0;
            LOAD      <= 1'b0;
            IN_CLR    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            offset    <= '0;
            col_idx   <= '0;
            gap_cnt   <= '0;
            scroll_q  <= 1'b0;
        end else begin
            column_id <= column_id_nxt;
            in_column <= in_column_nxt;
            LOAD      <= load_nxt;
            IN_CLR    <= clr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            case (state)
                S_IDLE: begin
                    if (offset_ld) begin
                        offset <= offset_in;
                    end
                    if (start) begin
                        scroll_q <= scroll_en;
                        col_idx  <= '0;
                    end
                end
                S_LD: begin
                    gap_cnt <= '0;
                    if (!last_col && !HAS_GAP) begin
                        col_idx <= col_idx + 5'd1;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_done) begin
                        col_idx <= col_idx + 5'd1;
                    end
                end
                S_FIN: begin
                    if (scroll_q) begin
                        offset <= offset + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pattern store is not reset; a same-cycle read of the written entry sees the old word
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            store[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_matrix_frame_loader.sv
// tb/tb_matrix_frame_loader.sv - randomized self-checking bench for matrix_frame_loader
module tb_matrix_frame_loader;
    localparam int N = 16;
    localparam int G = 1;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        clear_req;
    logic        scroll_en;
    logic        offset_ld;
    logic [4:0]  offset_in;
    logic [4:0]  column_id;
    logic [15:0] in_column;
    logic        LOAD;
    logic        IN_CLR;
    logic        busy;
    logic        done;
    logic [4:0]  offset;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_store [32];
    int          m_off = 0;

    always #5 CLK = ~CLK;

    matrix_frame_loader #(.NUM_COLS(N), .DEPTH(32), .GAP(G)) dut (
        .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .clear_req(clear_req), .scroll_en(scroll_en),
        .offset_ld(offset_ld), .offset_in(offset_in),
        .column_id(column_id), .in_column(in_column), .LOAD(LOAD), .IN_CLR(IN_CLR),
        .busy(busy), .done(done), .offset(offset)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {28'd0, LOAD, IN_CLR, busy, done}, 32'd0);
        check({tag, "_col"}, {27'd0, column_id}, 32'd0);
        check({tag, "_data"}, {16'd0, in_column}, 32'd0);
        check({tag, "_off"}, {27'd0, offset}, 32'd0);
    endtask

    task automatic write_store(input logic [4:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge CLK);
        m_store[a] = d;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    // One frame request; the expected timeline comes from the column/time formulas
    task automatic run_frame(input bit c, input bit s, input bit ld_off, input logic [4:0] off_val,
                             input int wr_k, input logic [4:0] wa, input logic [15:0] wd,
                             input int junk_k, input int rst_after);
        int t_len;
        int base_off;
        int loads;
        t_len = c + N + (N - 1) * G + 1;
        loads = 0;
        clear_req = c; scroll_en = s; start = 1'b1; offset_ld = ld_off; offset_in = off_val;
        @(posedge CLK);
        if (ld_off) m_off = off_val;
        base_off = m_off;
        for (int k = 0; k <= t_len + 3; k++) begin
            int  d;
            int  col;
            bit  exp_load;
            bit  exp_clr;
            bit  exp_busy;
            bit  exp_done;
            int  exp_off;
            @(negedge CLK);
            start = 1'b0; offset_ld = 1'b0; wr_en = 1'b0; clear_req = 1'b0; scroll_en = 1'b0;
            d = k - 1 - c;
            col = (d >= 0) ? d / (G + 1) : 0;
            exp_load = (d >= 0) && (d % (G + 1) == 0) && (col < N);
            exp_clr  = c && (k == 1);
            exp_busy = (k < t_len);
            exp_done = (k == t_len);
            exp_off  = (k >= t_len && s) ? (base_off + 1) % 32 : base_off;
            check("flags", {28'd0, LOAD, IN_CLR, busy, done},
                  {28'd0, exp_load, exp_clr, exp_busy, exp_done});
            check("offset", {27'd0, offset}, exp_off);
            if (exp_load) begin
                check("column_id", {27'd0, column_id}, col);
                check("in_column", {16'd0, in_column}, {16'd0, m_store[(col + base_off) % 32]});
                loads++;
            end
            if (k == wr_k) m_store[wa] = wd;
            if (rst_after > 0 && loads == rst_after) begin
                RESET = 1'b1;
                @(negedge CLK);
                RESET = 1'b0;
                check_all_zero("abort");
                m_off = 0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge CLK);
                    check("abort_idle", {28'd0, LOAD, IN_CLR, busy, done}, 32'd0);
                end
                return;
            end
            if (k + 1 == wr_k) begin
                wr_en = 1'b1; wr_addr = wa; wr_data = wd;
            end
            if (k == junk_k) begin
                start = 1'b1; offset_ld = 1'b1; offset_in = 5'd7;
            end
        end
        m_off = s ? (base_off + 1) % 32 : base_off;
    endtask

    initial begin
        RESET = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        clear_req = 1'b0; scroll_en = 1'b0; offset_ld = 1'b0; offset_in = '0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b0;
        @(negedge CLK);

        for (int k = 0; k < 32; k++) write_store(5'(k), 16'h0100 + 16'(k));
        // basic frame, then clear-first frame
        run_frame(0, 0, 0, 5'd0, -1, 5'd0, 16'd0, -1, 0);
        run_frame(1, 0, 0, 5'd0, -1, 5'd0, 16'd0, -1, 0);
        // scroll wrap: load 31 alongside start, then a second frame from 0
        run_frame(0, 1, 1, 5'd31, -1, 5'd0, 16'd0, -1, 0);
        run_frame(0, 1, 0, 5'd0, -1, 5'd0, 16'd0, -1, 0);
        // start and offset_ld mid-frame are ignored
        run_frame(1, 0, 0, 5'd0, -1, 5'd0, 16'd0, 10, 0);
        // reset after the fifth LOAD, then a fresh frame
        run_frame(0, 1, 0, 5'd0, -1, 5'd0, 16'd0, -1, 5);
        run_frame(0, 0, 0, 5'd0, -1, 5'd0, 16'd0, -1, 0);
        // write to entry 9 on the edge that reads column 9
        run_frame(0, 0, 1, 5'd0, 1 + 9 * (G + 1), 5'd9, 16'hBEEF, -1, 0);
        run_frame(0, 0, 0, 5'd0, -1, 5'd0, 16'd0, -1, 0);

        for (int r = 0; r < 6; r++) begin
            int          n_wr;
            bit          rc;
            bit          rs;
            bit          rl;
            logic [4:0]  ro;
            n_wr = $urandom_range(1, 4);
            for (int w = 0; w < n_wr; w++) write_store(5'($urandom_range(0, 31)), 16'($urandom));
            rc = 1'($urandom); rs = 1'($urandom); rl = 1'($urandom); ro = 5'($urandom);
            run_frame(rc, rs, rl, ro, $urandom_range(2, 30), 5'($urandom), 16'($urandom),
                      $urandom_range(3, 20), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
